// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready intake and gapless back-to-back frames.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               r_state;
    logic [FRAME_LEN-1:0] r_shreg;
    logic [CW-1:0]        r_cnt;

    logic [FRAME_LEN-1:0] w_frame;
    logic                 w_last;
    logic                 w_accept;

    // Frame laid out in transmit order: bit 0 goes on the wire first.
    always_comb begin
        w_frame = '0;
        for (int i = 0; i < WIDTH; i++)
            w_frame[i] = MSB_FIRST ? din[WIDTH-1-i] : din[i];
`ifdef PISO_SERIALIZER_PARITY_EN
        w_frame[WIDTH] = ^din;
`endif
    end

    assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(FRAME_LEN - 1));
    assign din_ready = (r_state == IDLE) || w_last;
    assign w_accept  = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (w_accept) begin
            // First bit is presented straight from the new word; the rest wait in r_shreg.
            r_state    <= SHIFT;
            r_shreg    <= w_frame >> 1;
            r_cnt      <= '0;
            sout       <= w_frame[0];
            sout_valid <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else if (r_state == SHIFT) begin
            if (w_last) begin
                r_state    <= IDLE;
                r_shreg    <= '0;
                r_cnt      <= '0;
                sout       <= 1'b0;
                sout_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                r_shreg <= r_shreg >> 1;
                r_cnt   <= r_cnt + CW'(1);
                sout    <= r_shreg[0];
                done    <= (r_cnt == CW'(FRAME_LEN - 2));
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one LSB-first and one MSB-first instance.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    typedef struct packed {
        logic b;
        logic d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din0 = '0, din1 = '0;
    logic       dv0 = 1'b0, dv1 = 1'b0;
    logic       rdy0, so0, sv0, bz0, dn0;
    logic       rdy1, so1, sv1, bz1, dn1;
    logic [1:0] rdy, so, sv, bz, dn;
    logic       mon_en = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;
    exp_t       q[2][$];
    exp_t       e_mon;

    assign rdy = {rdy1, rdy0};
    assign so  = {so1, so0};
    assign sv  = {sv1, sv0};
    assign bz  = {bz1, bz0};
    assign dn  = {dn1, dn0};

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
        .sout(so0), .sout_valid(sv0), .busy(bz0), .done(dn0)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
        .sout(so1), .sout_valid(sv1), .busy(bz1), .done(dn1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int k, input logic [7:0] w);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b = (k == 1) ? w[7-i] : w[i];
            e.d = (i == FL - 1);
            q[k].push_back(e);
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        e.b = ^w;
        e.d = 1'b1;
        q[k].push_back(e);
`endif
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge, din_valid still high.
    task automatic send(input int k, input logic [7:0] w, output int waited);
        if (k == 0) begin din0 = w; dv0 = 1'b1; end
        else        begin din1 = w; dv1 = 1'b1; end
        waited = 0;
        while (!rdy[k] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy[k]) chk("send_timeout", {31'd0, rdy[k]}, 1);
        @(posedge clk);
        push_frame(k, w);
        @(negedge clk);
    endtask

    task automatic drain();
        int c = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("drain", q[0].size() + q[1].size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Any queued bit means that DUT must be mid-frame right now.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("valid%0d", k), {31'd0, sv[k]}, {31'd0, q[k].size() != 0});
                chk($sformatf("busy%0d", k), {31'd0, bz[k]}, {31'd0, q[k].size() != 0});
                if (q[k].size() != 0) begin
                    e_mon = q[k].pop_front();
                    chk($sformatf("sout%0d", k), {31'd0, so[k]}, {31'd0, e_mon.b});
                    chk($sformatf("done%0d", k), {31'd0, dn[k]}, {31'd0, e_mon.d});
                end else begin
                    chk($sformatf("idle_done%0d", k), {31'd0, dn[k]}, 0);
                    chk($sformatf("idle_sout%0d", k), {31'd0, so[k]}, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset held two cycles with a word offered
        rst = 1'b1; din0 = 8'hFF; dv0 = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        chk("rst_rdy", {31'd0, rdy0}, 1);
        @(negedge clk);
        chk("rst_rdy2", {31'd0, rdy0}, 1);
        rst = 1'b0; dv0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_rdy", {31'd0, rdy0}, 1);

        // Single frame
        send(0, 8'hA5, n);
        chk("single_wait", n, 0);
        chk("single_rdy_mid", {31'd0, rdy0}, 0);
        dv0 = 1'b0;
        drain();

        // Back-to-back, din_valid held
        send(0, 8'hA5, n);
        send(0, 8'h3C, n);
        chk("b2b_wait", n, FL - 1);
        dv0 = 1'b0;
        drain();

        // MSB first, next word offered mid-frame and word changed after accept
        send(1, 8'h81, n);
        chk("msb_rdy_mid", {31'd0, rdy1}, 0);
        send(1, 8'h5A, n);
        chk("msb_wait", n, FL - 1);
        dv1 = 1'b0;
        din1 = 8'h00;
        drain();

        // Reset after three bits of 8'hFF
        send(0, 8'hFF, n);
        dv0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        q[0].delete();
        q[1].delete();
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, bz0}, 0);
        chk("midrst_rdy", {31'd0, rdy0}, 1);
        send(0, 8'h01, n);
        dv0 = 1'b0;
        drain();

        // Parity-sensitive words
        send(0, 8'hA5, n);
        dv0 = 1'b0;
        @(negedge clk);
        send(0, 8'h07, n);
        dv0 = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
